// File: rtl/se_mul_issuer_if.sv
// Issuer bundle: job control, feature-map/scale read ports and multiplier operand/response lines.
// SE_MUL_ISSUER_CHK_EN adds the returned-address input and the sticky err output.
interface se_mul_issuer_if #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned CH_AW  = 10,
    parameter int unsigned PIX_W  = 13
);
    // Job control
    logic                start;
    logic [CH_AW:0]      num_channels;
    logic [PIX_W:0]      pixels_per_channel;
    logic                pause;
    logic                busy;
    logic                done;

    // Feature-map and scale memories
    logic                fm_rd_en;
    logic [ADDR_W-1:0]   fm_rd_addr;
    logic [DATA_W-1:0]   fm_rd_data;
    logic                sc_rd_en;
    logic [CH_AW-1:0]    sc_rd_addr;
    logic [DATA_W-1:0]   sc_rd_data;

    // Multiplier
    logic [DATA_W-1:0]   mul_a;
    logic [DATA_W-1:0]   mul_b;
    logic                mul_start_flag;
    logic [ADDR_W-1:0]   mul_in_address;
    logic                mul_valid;
`ifdef SE_MUL_ISSUER_CHK_EN
    logic [ADDR_W-1:0]   mul_out_address;
    logic                err;
`endif

`ifdef SE_MUL_ISSUER_CHK_EN
    modport master (
        input  start, num_channels, pixels_per_channel, pause,
        input  fm_rd_data, sc_rd_data, mul_valid, mul_out_address,
        output busy, done, fm_rd_en, fm_rd_addr, sc_rd_en, sc_rd_addr,
        output mul_a, mul_b, mul_start_flag, mul_in_address, err
    );

    modport slave (
        output start, num_channels, pixels_per_channel, pause,
        output fm_rd_data, sc_rd_data, mul_valid, mul_out_address,
        input  busy, done, fm_rd_en, fm_rd_addr, sc_rd_en, sc_rd_addr,
        input  mul_a, mul_b, mul_start_flag, mul_in_address, err
    );
`else
    modport master (
        input  start, num_channels, pixels_per_channel, pause,
        input  fm_rd_data, sc_rd_data, mul_valid,
        output busy, done, fm_rd_en, fm_rd_addr, sc_rd_en, sc_rd_addr,
        output mul_a, mul_b, mul_start_flag, mul_in_address
    );

    modport slave (
        output start, num_channels, pixels_per_channel, pause,
        output fm_rd_data, sc_rd_data, mul_valid,
        input  busy, done, fm_rd_en, fm_rd_addr, sc_rd_en, sc_rd_addr,
        input  mul_a, mul_b, mul_start_flag, mul_in_address
    );
`endif
endinterface

// File: rtl/se_mul_issuer.sv
// SE-block multiplier job sequencer: channel-major feature/scale reads, operand issue, completion count.
// Optional response-order checker enabled by defining SE_MUL_ISSUER_CHK_EN.
module se_mul_issuer #(
    parameter int unsigned DATA_W = 14,
    parameter int unsigned ADDR_W = 13,
    parameter int unsigned CH_AW  = 10,
    parameter int unsigned PIX_W  = 13
) (
    input logic             clk,
    input logic             rst,
    se_mul_issuer_if.master bus
);

    localparam int unsigned TOT_W = CH_AW + PIX_W + 2;

    typedef enum logic [1:0] {StIdle, StRun, StDrain, StDone} state_e;

    state_e state_q, state_d;

    logic [ADDR_W-1:0] idx_q, idx_d;
    logic [CH_AW-1:0]  ch_q, ch_d;
    logic [PIX_W:0]    pix_q, pix_d;
    logic [PIX_W:0]    ppc_q, ppc_d;
    logic [TOT_W-1:0]  total_q, total_d;
    logic [TOT_W-1:0]  cnt_q, cnt_d;

    // Stage 1: read in flight; stage 2: registered operands toward the multiplier
    logic              rd_vld_q, rd_vld_d;
    logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
    logic              mul_vld_q, mul_vld_d;
    logic [DATA_W-1:0] mul_a_q, mul_a_d;
    logic [DATA_W-1:0] mul_b_q, mul_b_d;
    logic [ADDR_W-1:0] mul_addr_q, mul_addr_d;

    logic start_acc;
    logic job_empty;
    logic issue;
    logic last_issue;
    logic count_en;
    logic drained;

    always_comb begin
        start_acc  = (state_q == StIdle) && bus.start;
        job_empty  = (bus.num_channels == '0) || (bus.pixels_per_channel == '0);
        issue      = (state_q == StRun) && !bus.pause;
        last_issue = issue && (TOT_W'(idx_q) == total_q - TOT_W'(1));
        count_en   = bus.mul_valid && ((state_q == StRun) || (state_q == StDrain));
    end

    // ---------------- FSM ----------------
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            StIdle: begin
                if (bus.start) begin
                    state_d = job_empty ? StDone : StRun;
                end
            end
            StRun: begin
                if (last_issue) begin
                    state_d = StDrain;
                end
            end
            StDrain: begin
                if (drained) begin
                    state_d = StDone;
                end
            end
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    always_comb begin
        bus.busy       = (state_q == StRun) || (state_q == StDrain);
        bus.done       = (state_q == StDone);
        bus.fm_rd_en   = issue;
        bus.sc_rd_en   = issue;
        bus.fm_rd_addr = issue ? idx_q : '0;
        bus.sc_rd_addr = issue ? ch_q : '0;
    end

    // ---------------- Counters ----------------
    always_comb begin
        idx_d   = idx_q;
        ch_d    = ch_q;
        pix_d   = pix_q;
        ppc_d   = ppc_q;
        total_d = total_q;
        cnt_d   = cnt_q;
        if (start_acc) begin
            ppc_d   = bus.pixels_per_channel;
            total_d = TOT_W'(bus.num_channels) * TOT_W'(bus.pixels_per_channel);
            idx_d   = '0;
            ch_d    = '0;
            pix_d   = '0;
            cnt_d   = '0;
        end else begin
            if (issue) begin
                idx_d = idx_q + ADDR_W'(1);
                if (pix_q == ppc_q - (PIX_W + 1)'(1)) begin
                    pix_d = '0;
                    ch_d  = ch_q + CH_AW'(1);
                end else begin
                    pix_d = pix_q + (PIX_W + 1)'(1);
                end
            end
            if (count_en) begin
                cnt_d = cnt_q + TOT_W'(1);
            end
        end
        // Looks at cnt_d so the final mul_valid moves to DONE on the very next edge
        drained = (cnt_d >= total_q);
    end

    // ---------------- Issue pipeline ----------------
    always_comb begin
        rd_vld_d   = issue;
        rd_addr_d  = issue ? idx_q : '0;
        mul_vld_d  = rd_vld_q;
        mul_a_d    = rd_vld_q ? bus.fm_rd_data : '0;
        mul_b_d    = rd_vld_q ? bus.sc_rd_data : '0;
        mul_addr_d = rd_vld_q ? rd_addr_q : '0;
    end

    always_comb begin
        bus.mul_start_flag = mul_vld_q;
        bus.mul_a          = mul_a_q;
        bus.mul_b          = mul_b_q;
        bus.mul_in_address = mul_addr_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q      <= '0;
            ch_q       <= '0;
            pix_q      <= '0;
            ppc_q      <= '0;
            total_q    <= '0;
            cnt_q      <= '0;
            rd_vld_q   <= 1'b0;
            rd_addr_q  <= '0;
            mul_vld_q  <= 1'b0;
            mul_a_q    <= '0;
            mul_b_q    <= '0;
            mul_addr_q <= '0;
        end else begin
            idx_q      <= idx_d;
            ch_q       <= ch_d;
            pix_q      <= pix_d;
            ppc_q      <= ppc_d;
            total_q    <= total_d;
            cnt_q      <= cnt_d;
            rd_vld_q   <= rd_vld_d;
            rd_addr_q  <= rd_addr_d;
            mul_vld_q  <= mul_vld_d;
            mul_a_q    <= mul_a_d;
            mul_b_q    <= mul_b_d;
            mul_addr_q <= mul_addr_d;
        end
    end

`ifdef SE_MUL_ISSUER_CHK_EN
    // ---------------- Response-order checker ----------------
    logic [ADDR_W-1:0] exp_addr_q, exp_addr_d;
    logic              err_q, err_d;

    always_comb begin
        exp_addr_d = exp_addr_q;
        err_d      = err_q;
        if (start_acc) begin
            exp_addr_d = '0;
            err_d      = 1'b0;
        end else if (bus.mul_valid) begin
            if (state_q == StIdle) begin
                err_d = 1'b1;
            end else begin
                // cnt_q already at total means this response has no matching issue
                if ((bus.mul_out_address != exp_addr_q) || (cnt_q >= total_q)) begin
                    err_d = 1'b1;
                end
                exp_addr_d = exp_addr_q + ADDR_W'(1);
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            exp_addr_q <= '0;
            err_q      <= 1'b0;
        end else begin
            exp_addr_q <= exp_addr_d;
            err_q      <= err_d;
        end
    end

    always_comb begin
        bus.err = err_q;
    end
`endif

endmodule

// File: tb/tb_se_mul_issuer.sv
// Randomized scoreboard bench for se_mul_issuer with memory and 2-cycle multiplier models.
// Define SE_MUL_ISSUER_CHK_EN to also exercise the response-order checker.
module tb_se_mul_issuer;

    localparam int unsigned DATA_W = 14;
    localparam int unsigned ADDR_W = 13;
    localparam int unsigned CH_AW  = 10;
    localparam int unsigned PIX_W  = 13;

    logic clk = 1'b0;
    logic rst = 1'b1;
    always #5 clk = ~clk;

    se_mul_issuer_if #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CH_AW  (CH_AW),
        .PIX_W  (PIX_W)
    ) bus ();

    se_mul_issuer #(
        .DATA_W (DATA_W),
        .ADDR_W (ADDR_W),
        .CH_AW  (CH_AW),
        .PIX_W  (PIX_W)
    ) u_dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    int n_checks = 0;
    int n_err    = 0;
    int done_cnt = 0;
    bit mon_en   = 1'b0;
    bit swap_en  = 1'b0;

    logic [DATA_W-1:0] fm_mem [256];
    logic [DATA_W-1:0] sc_mem [16];
    logic [40:0]       sb [$];

    logic [63:0] flag_v, busy_v, done_v, rden_v, any_v, err_v;

    task automatic check(input string name, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, got, exp, $time);
        end
    endtask

    function automatic logic [63:0] span(input int lo, input int hi);
        logic [63:0] v = '0;
        for (int i = lo; i <= hi; i++) v[i] = 1'b1;
        return v;
    endfunction

    // Memories: one-cycle registered read
    initial begin
        bus.fm_rd_data = '0;
        bus.sc_rd_data = '0;
    end
    always @(posedge clk) begin
        bus.fm_rd_data <= (bus.fm_rd_en === 1'b1) ? fm_mem[bus.fm_rd_addr[7:0]] : '0;
        bus.sc_rd_data <= (bus.sc_rd_en === 1'b1) ? sc_mem[bus.sc_rd_addr[3:0]] : '0;
    end

    // Multiplier: result-valid two cycles after the operand strobe
    logic              mv1, mv2;
    logic [ADDR_W-1:0] ma1, ma2;
    always @(posedge clk) begin
        if (rst) begin
            mv1 <= 1'b0; mv2 <= 1'b0; ma1 <= '0; ma2 <= '0;
        end else begin
            mv1 <= bus.mul_start_flag; ma1 <= bus.mul_in_address;
            mv2 <= mv1;                ma2 <= ma1;
        end
    end
    assign bus.mul_valid = mv2;
`ifdef SE_MUL_ISSUER_CHK_EN
    assign bus.mul_out_address = (swap_en && ma2 == 13'd2) ? 13'd3 :
                                 (swap_en && ma2 == 13'd3) ? 13'd2 : ma2;
`endif

    function automatic logic any_out();
        logic v;
        v = |{bus.fm_rd_en, bus.fm_rd_addr, bus.sc_rd_en, bus.sc_rd_addr, bus.mul_a, bus.mul_b,
              bus.mul_start_flag, bus.mul_in_address, bus.busy, bus.done};
`ifdef SE_MUL_ISSUER_CHK_EN
        v = v | bus.err;
`endif
        return v;
    endfunction

    // Monitor: pops the scoreboard on every operand strobe
    always @(negedge clk) begin
        logic [40:0] exp;
        if (mon_en) begin
            if (bus.mul_start_flag === 1'b1) begin
                if (sb.size() == 0) begin
                    check("unexpected_strobe", 64'(sb.size()), 64'd1);
                end else begin
                    exp = sb.pop_front();
                    check("operand", {bus.mul_in_address, bus.mul_a, bus.mul_b}, 64'(exp));
                end
            end else begin
                check("bubble_zero", {bus.mul_in_address, bus.mul_a, bus.mul_b}, 64'd0);
            end
            if (bus.pause === 1'b1) check("pause_no_read", {bus.fm_rd_en, bus.sc_rd_en}, 64'd0);
            if (bus.done === 1'b1) done_cnt++;
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Fills memories and pushes the expected operand stream of a channel-major walk
    task automatic load_job(input int nch, input int ppc, input bit ramp);
        for (int i = 0; i < 256; i++) fm_mem[i] = ramp ? DATA_W'(i + 1) : DATA_W'($urandom);
        for (int c = 0; c < 16; c++) begin
            if (ramp) sc_mem[c] = (c == 0) ? 14'h200 : 14'h100;
            else      sc_mem[c] = DATA_W'($urandom);
        end
        for (int i = 0; i < nch * ppc; i++)
            sb.push_back({ADDR_W'(i), fm_mem[i], sc_mem[i / ppc]});
        bus.num_channels       = (CH_AW + 1)'(nch);
        bus.pixels_per_channel = (PIX_W + 1)'(ppc);
    endtask

    // Runs a fixed window from a start in cycle 0, recording per-cycle output bits
    task automatic watch(input int ncyc, input int p_lo, input int p_hi, input bit restart,
                         input int rst_at);
        flag_v = '0; busy_v = '0; done_v = '0; rden_v = '0; any_v = '0; err_v = '0;
        for (int c = 0; c < ncyc; c++) begin
            bus.start = (c == 0) || (restart && (c == 2 || c == 8));
            bus.pause = (c >= p_lo) && (c <= p_hi);
            rst       = (c == rst_at);
            @(negedge clk);
            flag_v[c] = bus.mul_start_flag;
            busy_v[c] = bus.busy;
            done_v[c] = bus.done;
            rden_v[c] = bus.fm_rd_en;
            any_v[c]  = any_out();
`ifdef SE_MUL_ISSUER_CHK_EN
            err_v[c]  = bus.err;
`endif
            step();
            if (c == rst_at) sb.delete();
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        rst       = 1'b0;
    endtask

    task automatic check_basic_job(input string tag);
        check({tag, "_flag"}, flag_v, span(3, 8));
        check({tag, "_busy"}, busy_v, span(1, 10));
        check({tag, "_done"}, done_v, span(11, 11));
        check({tag, "_rden"}, rden_v, span(1, 6));
        check({tag, "_sb_empty"}, 64'(sb.size()), 64'd0);
    endtask

    task automatic random_job(input int nch, input int ppc);
        int  c;
        int  d0;
        bit  seen;
        load_job(nch, ppc, 1'b0);
        d0   = done_cnt;
        seen = 1'b0;
        c    = 0;
        bus.start = 1'b1;
        while (!seen && c < 300) begin
            bus.pause = ($urandom_range(3) == 0);
            @(negedge clk);
            if (bus.done === 1'b1) seen = 1'b1;
            step();
            bus.start = ($urandom_range(7) == 0);
            c++;
        end
        bus.start = 1'b0;
        bus.pause = 1'b0;
        check("rand_done_seen", 64'(seen), 64'd1);
        repeat (4) step();
        check("rand_single_done", 64'(done_cnt - d0), 64'd1);
        check("rand_sb_empty", 64'(sb.size()), 64'd0);
        check("rand_idle", 64'(bus.busy), 64'd0);
`ifdef SE_MUL_ISSUER_CHK_EN
        check("rand_no_err", 64'(bus.err), 64'd0);
`endif
    endtask

    initial begin
        bus.start              = 1'b0;
        bus.pause              = 1'b0;
        bus.num_channels       = '0;
        bus.pixels_per_channel = '0;
        repeat (3) @(posedge clk);
        #1;
        rst    = 1'b0;
        mon_en = 1'b1;
        @(negedge clk);
        check("reset_outputs", 64'(any_out()), 64'd0);
        step();

        // Basic 2x3 job
        load_job(2, 3, 1'b1);
        watch(16, -1, -1, 1'b0, -1);
        check_basic_job("basic");

        // Two pause cycles while idx=2
        load_job(2, 3, 1'b1);
        watch(18, 3, 4, 1'b0, -1);
        check("pause_flag", flag_v, span(3, 4) | span(7, 10));
        check("pause_rden", rden_v, span(1, 2) | span(5, 8));
        check("pause_done", done_v, span(13, 13));
        check("pause_busy", busy_v, span(1, 12));
        check("pause_sb_empty", 64'(sb.size()), 64'd0);

        // Empty jobs
        load_job(0, 3, 1'b1);
        watch(6, -1, -1, 1'b0, -1);
        check("empty_ch_rden", rden_v, 64'd0);
        check("empty_ch_flag", flag_v, 64'd0);
        check("empty_ch_busy", busy_v, 64'd0);
        check("empty_ch_done", 64'((done_v == span(1, 1)) || (done_v == span(2, 2))), 64'd1);
        load_job(4, 0, 1'b1);
        watch(6, -1, -1, 1'b0, -1);
        check("empty_px_rden", rden_v, 64'd0);
        check("empty_px_busy", busy_v, 64'd0);
        check("empty_px_done", 64'((done_v == span(1, 1)) || (done_v == span(2, 2))), 64'd1);

        // Start re-pulsed in RUN and DRAIN
        load_job(2, 3, 1'b1);
        watch(16, -1, -1, 1'b1, -1);
        check_basic_job("restart");

        // Reset mid-job at idx=3, then a clean job
        load_job(2, 3, 1'b1);
        watch(10, -1, -1, 1'b0, 4);
        check("rst_outputs_zero", any_v & span(5, 9), 64'd0);
        check("rst_no_done", done_v, 64'd0);
        load_job(2, 3, 1'b1);
        watch(16, -1, -1, 1'b0, -1);
        check_basic_job("after_rst");

`ifdef SE_MUL_ISSUER_CHK_EN
        // Responses returned as 0,1,3,2: sticky err until the next start
        swap_en = 1'b1;
        load_job(2, 3, 1'b1);
        watch(16, -1, -1, 1'b0, -1);
        check("chk_err", err_v, span(8, 15));
        check("chk_done", done_v, span(11, 11));
        swap_en = 1'b0;
        load_job(2, 3, 1'b1);
        watch(16, -1, -1, 1'b0, -1);
        check("chk_err_cleared", err_v, span(0, 0));
`endif

        for (int j = 0; j < 25; j++) begin
            random_job(int'($urandom_range(0, 4)), int'($urandom_range(0, 6)));
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish, errors=%0d", n_err);
        $fatal(1);
    end

endmodule
